// File: rtl/uart_tx_frame.sv
// UART frame serialiser: start bit, DATA_BITS data LSB-first, optional parity, 1 or 2 stop bits.
// Optional line-break generation is enabled by defining UART_TX_BREAK_EN (adds input brk).
module uart_tx_frame #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                 Tx_clk,
  input  logic                 rst,
  input  logic [DATA_BITS-1:0] din,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic                 parity_en,
  input  logic                 parity_odd,
  input  logic                 two_stop,
`ifdef UART_TX_BREAK_EN
  input  logic                 brk,
`endif
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    BREAK   = 3'd5,
    BRK_REC = 3'd6
  } state_t;

  state_t               state_reg, state_next;
  logic [CW-1:0]        baud_cnt_reg;
  logic [BW-1:0]        bit_idx_reg;
  logic [DATA_BITS-1:0] shift_reg;
  logic                 par_en_reg;
  logic                 par_bit_reg;
  logic                 two_stop_reg;
  logic                 stop_idx_reg;
  logic                 tx_reg;
  logic                 tx_ready_reg;
  logic                 tx_busy_reg;
  logic                 tx_done_reg;
  logic                 line_bit;
  logic                 accept;
  logic                 bit_end;
  logic                 last_bit;
  logic                 counting;

  assign accept   = tx_valid && tx_ready_reg;
  assign bit_end  = (baud_cnt_reg == CW'(CLKS_PER_BIT - 1));
  assign last_bit = (bit_idx_reg == BW'(DATA_BITS - 1));
  assign counting = (state_reg == START) || (state_reg == DATA) || (state_reg == PARITY) ||
                    (state_reg == STOP) || (state_reg == BRK_REC);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = START;
`ifdef UART_TX_BREAK_EN
        else if (brk) state_next = BREAK;
`endif
      end
      START:  if (bit_end) state_next = DATA;
      DATA:   if (bit_end && last_bit) state_next = par_en_reg ? PARITY : STOP;
      PARITY: if (bit_end) state_next = STOP;
      STOP:   if (bit_end && (stop_idx_reg || !two_stop_reg)) state_next = IDLE;
`ifdef UART_TX_BREAK_EN
      BREAK:   if (!brk) state_next = BRK_REC;
      BRK_REC: if (bit_end) state_next = IDLE;
`endif
      default: state_next = IDLE;
    endcase
  end

  // The line value follows the state one cycle later, so the start bit appears the edge after accept.
  always_comb begin
    line_bit = 1'b1;
    case (state_reg)
      START:   line_bit = 1'b0;
      DATA:    line_bit = shift_reg[0];
      PARITY:  line_bit = par_bit_reg;
      BREAK:   line_bit = 1'b0;
      default: line_bit = 1'b1;
    endcase
  end

  always_ff @(posedge Tx_clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      shift_reg    <= '0;
      par_en_reg   <= 1'b0;
      par_bit_reg  <= 1'b0;
      two_stop_reg <= 1'b0;
      stop_idx_reg <= 1'b0;
      tx_reg       <= 1'b1;
      tx_ready_reg <= 1'b1;
      tx_busy_reg  <= 1'b0;
      tx_done_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      tx_reg       <= line_bit;
      tx_ready_reg <= (state_next == IDLE);
      tx_busy_reg  <= (state_next != IDLE);
      tx_done_reg  <= (state_reg == STOP) && (state_next == IDLE);
      if (accept) begin
        shift_reg    <= din;
        par_en_reg   <= parity_en;
        par_bit_reg  <= (^din) ^ parity_odd;
        two_stop_reg <= two_stop;
        baud_cnt_reg <= '0;
        bit_idx_reg  <= '0;
        stop_idx_reg <= 1'b0;
      end else if (counting) begin
        baud_cnt_reg <= bit_end ? '0 : baud_cnt_reg + CW'(1);
        if (bit_end && (state_reg == DATA)) begin
          shift_reg   <= shift_reg >> 1;
          bit_idx_reg <= bit_idx_reg + BW'(1);
        end
        if (bit_end && (state_reg == STOP)) stop_idx_reg <= 1'b1;
      end else begin
        baud_cnt_reg <= '0;
      end
    end
  end

  assign tx       = tx_reg;
  assign tx_ready = tx_ready_reg;
  assign tx_busy  = tx_busy_reg;
  assign tx_done  = tx_done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame at CLKS_PER_BIT=4, DATA_BITS=8; frames written out bit by bit.
module tb_uart_tx_frame;

  logic       Tx_clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       parity_en = 1'b0;
  logic       parity_odd = 1'b0;
  logic       two_stop = 1'b0;
`ifdef UART_TX_BREAK_EN
  logic       brk = 1'b0;
`endif
  logic       tx;
  logic       tx_busy;
  logic       tx_done;

  int total = 0;
  int bad   = 0;

  uart_tx_frame #(.DATA_BITS(8), .CLKS_PER_BIT(4)) dut (
    .Tx_clk     (Tx_clk),
    .rst        (rst),
    .din        (din),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .parity_en  (parity_en),
    .parity_odd (parity_odd),
    .two_stop   (two_stop),
`ifdef UART_TX_BREAK_EN
    .brk        (brk),
`endif
    .tx         (tx),
    .tx_busy    (tx_busy),
    .tx_done    (tx_done)
  );

  always #5 Tx_clk = ~Tx_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge Tx_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  // Present a frame and clock the accept edge; tx must still be idle-high on that edge.
  task automatic start_frame(input logic [7:0] d, input logic pe, input logic po,
                             input logic ts, input logic hold, input string name);
    din = d; parity_en = pe; parity_odd = po; two_stop = ts;
    tx_valid = 1'b1;
    tick();
    chk({name, "_acc_tx"}, tx, 1'b1);
    chk({name, "_acc_ready"}, tx_ready, 1'b0);
    chk({name, "_acc_busy"}, tx_busy, 1'b1);
    if (!hold) tx_valid = 1'b0;
  endtask

  // bits[i] is the i-th serial bit; inputs are overwritten early to prove they were latched.
  task automatic frame_body(input logic [11:0] bits, input int nbits, input logic [7:0] nd,
                            input logic npe, input logic npo, input logic nts, input string name);
    int len;
    len = nbits * 4;
    for (int c = 1; c <= len; c++) begin
      tick();
      if (c == 2) begin
        din = nd; parity_en = npe; parity_odd = npo; two_stop = nts;
      end
      chk({name, "_tx"}, tx, bits[(c - 1) / 4]);
      chk({name, "_done"}, tx_done, c == len);
      chk({name, "_ready"}, tx_ready, c == len);
      chk({name, "_busy"}, tx_busy, c != len);
    end
    $display("frame %s: %0d cycles checked", name, len);
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", tx, 1'b1);
    chk("rst_ready", tx_ready, 1'b1);
    chk("rst_busy", tx_busy, 1'b0);
    chk("rst_done", tx_done, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    for (int i = 0; i < 3; i++) begin
      tick();
      chk("idle_tx", tx, 1'b1);
      chk("idle_ready", tx_ready, 1'b1);
    end

    // 0xA5 8N1
    start_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, "a5_8n1");
    frame_body({1'b1, 8'hA5, 1'b0}, 10, 8'h00, 1'b1, 1'b1, 1'b1, "a5_8n1");
    tick();

    // 0xA5 even parity: four ones -> parity 0
    start_frame(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, "a5_8e1");
    frame_body({1'b1, 1'b0, 8'hA5, 1'b0}, 11, 8'hFF, 1'b0, 1'b1, 1'b1, "a5_8e1");
    tick();

    // 0xA5 odd parity -> parity 1
    start_frame(8'hA5, 1'b1, 1'b1, 1'b0, 1'b0, "a5_8o1");
    frame_body({1'b1, 1'b1, 8'hA5, 1'b0}, 11, 8'h00, 1'b0, 1'b0, 1'b1, "a5_8o1");
    tick();

    // 0x01 two stop bits, two_stop dropped mid-frame
    start_frame(8'h01, 1'b0, 1'b0, 1'b1, 1'b0, "01_8n2");
    frame_body({1'b1, 1'b1, 8'h01, 1'b0}, 11, 8'hFE, 1'b1, 1'b0, 1'b0, "01_8n2");
    tick();

    // back-to-back with tx_valid held: one idle-high gap cycle between frames
    start_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b1, "b2b_55");
    frame_body({1'b1, 8'h55, 1'b0}, 10, 8'h0F, 1'b0, 1'b0, 1'b0, "b2b_55");
    tick();
    chk("b2b_gap_tx", tx, 1'b1);
    chk("b2b_gap_ready", tx_ready, 1'b0);
    chk("b2b_gap_busy", tx_busy, 1'b1);
    tx_valid = 1'b0;
    frame_body({1'b1, 8'h0F, 1'b0}, 10, 8'h00, 1'b0, 1'b0, 1'b0, "b2b_0f");
    tick();
    chk("b2b_after_tx", tx, 1'b1);
    chk("b2b_after_ready", tx_ready, 1'b1);

    // reset during data bit 3 of 0xFF
    start_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, "rst_ff");
    for (int i = 0; i < 18; i++) tick();
    chk("rst_ff_busy_before", tx_busy, 1'b1);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_tx", tx, 1'b1);
    chk("rst_mid_busy", tx_busy, 1'b0);
    chk("rst_mid_ready", tx_ready, 1'b1);
    chk("rst_mid_done", tx_done, 1'b0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_tx", tx, 1'b1);
    chk("post_rst_ready", tx_ready, 1'b1);

    start_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b0, "3c_8n1");
    frame_body({1'b1, 8'h3C, 1'b0}, 10, 8'h00, 1'b1, 1'b0, 1'b1, "3c_8n1");
    tick();
    chk("end_tx", tx, 1'b1);
    chk("end_done", tx_done, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART serialiser: the next-generation transmitter for the Tx path, sitting between the Tx FIFO read side and the serial line.
- Generalised data width; internal baud divider; runtime parity (none/even/odd) computed in-block; 1 or 2 stop bits.
- Valid/ready input handshake and a one-cycle frame-done pulse.
- Frame: start bit, data LSB-first, optional parity, stop bit(s).

Parameters:
DATA_BITS  8  data bits per frame (legal 5..9)
CLKS_PER_BIT  16  Tx_clk cycles per serial bit (>=2)

Ports:
Tx_clk  in  1  block clock; all state on rising edge
rst  in  1  asynchronous, active-high reset
din  in  DATA_BITS  frame payload, sampled on accept
tx_valid  in  1  payload valid
tx_ready  out  1  block can accept a frame
parity_en  in  1  1 = append parity bit
parity_odd  in  1  0 = even parity, 1 = odd parity (ignored if parity_en=0)
two_stop  in  1  0 = one stop bit, 1 = two stop bits
tx  out  1  serial line, idle high
tx_busy  out  1  frame in progress
tx_done  out  1  one-cycle pulse at frame end

Behaviour:
- Reset (async, immediate): state IDLE, tx=1, tx_ready=1, tx_busy=0, tx_done=0, all counters 0. Reset mid-frame aborts it; tx returns high with no partial stop bit.
- States: IDLE, START, DATA, PARITY, STOP.
- Accept: tx_valid && tx_ready on a rising edge latches din, parity_en, parity_odd, two_stop into shadow registers. Config-input changes mid-frame have no effect.
- tx_ready=1 only in IDLE. tx_busy = !IDLE.
- Latency: accept at edge k -> tx low (START) from edge k+1. All outputs registered.
- Bit timing: each bit held exactly CLKS_PER_BIT cycles; baud counter 0..CLKS_PER_BIT-1, reloaded at each bit boundary.
- DATA: bit index 0..DATA_BITS-1, LSB first; shift register shifts right at bit boundaries.
- PARITY (entered only if parity_en latched): bit = ^data XOR parity_odd, computed from the latched payload.
- STOP: tx=1 for 1 or 2 bit times per latched two_stop.
- Transitions:
  - IDLE->START on accept.
  - START->DATA after 1 bit time.
  - DATA->PARITY or DATA->STOP after the last data bit.
  - PARITY->STOP after 1 bit time.
  - STOP->IDLE after the last stop bit.
- tx_done: high for exactly one cycle, on the cycle IDLE is re-entered.
- Back-to-back: tx_valid held high -> re-accept on the first IDLE cycle. Gap is one Tx_clk cycle of tx=1 added to the stop time; no other inter-frame gap.
- Frame length in cycles: (1 + DATA_BITS + parity_en + 1 + two_stop) * CLKS_PER_BIT.
- tx_valid with tx_ready=0: ignored, not queued; the source holds it.
- Undefined state encodings recover to IDLE with tx=1.

Optional Feature:
UART_TX_BREAK_EN
- Defined:
  - adds input port brk (1 bit).
  - brk=1 while IDLE: tx driven 0, tx_ready=0 for as long as brk is held.
  - brk asserted mid-frame: no effect until the frame ends.
  - On brk release: tx=1 for one full bit time, then tx_ready=1.
- Undefined: no brk port; behaviour exactly as above.

Test Plan:
- CLKS_PER_BIT=4, din=0xA5, 8N1 -> tx: 0 x4 cycles, then 1,0,1,0,0,1,0,1 each 4 cycles, then 1 x4; tx_done pulses once 40 cycles after accept; tx_ready low throughout.
- din=0xA5, parity_en=1, parity_odd=0 -> parity bit 0; parity_odd=1 -> parity bit 1; frame 44 cycles.
- din=0x01, two_stop=1, parity off -> stop high 8 cycles; frame 44 cycles; toggling two_stop mid-frame changes nothing.
- tx_valid held high for 0x55 then 0x0F -> second start bit begins exactly one cycle after the first tx_done; both frames bit-exact.
- rst asserted during the data bit 3 of 0xFF -> tx=1, tx_busy=0, tx_ready=1 in the same cycle; after release, next frame 0x3C is transmitted correctly.
- With UART_TX_BREAK_EN: brk=1 for 50 cycles while idle -> tx low 50 cycles, tx_ready=0; release -> tx high, tx_ready=1 after 4 cycles.
